data_store_controller: RTL and testbench
========================================

// Module: data_store_controller
// PURPOSE
//  Write-side companion of the multicore data-memory read path: accepts one 16-bit store
//  per core from the four cores and serializes them onto the single data-memory write port.
//  Per core it holds a one-entry store buffer, and a round-robin arbiter picks the next store.
//  It sits between the core store interfaces and the data memory's MEMWRITE/address/data inputs.
// PARAMETERS
//  ADDR_W   16   data-memory address width
//  DATA_W   16   store data width (one word per core)
// PORTS
//  clk      in   1       clock, rising edge
//  rstn     in   1       asynchronous active-low reset
//  MW       in   4       per-core store request, bit i = core i+1
//  MADDR1-4 in   ADDR_W  store address, cores 1..4
//  MDIN1-4  in   DATA_W  store data, cores 1..4
//  BUSY     out  4       bit i: core i's buffer is full, so a new request is not accepted
//  WDONE    out  4       bit i: one-cycle pulse when core i's store is issued to memory
//  MEMWRITE out  1       data-memory write enable
//  WADDR    out  ADDR_W  data-memory write address
//  WDATA    out  DATA_W  data-memory write data
// BEHAVIOUR
//  - Reset: one clock (clk); reset asynchronous, active-low (rstn).
//    While rstn=0, all outputs are 0, every buffer valid bit is 0 and the RR pointer is 0.
//  - Accept: at a clk edge with MW[i]=1 and valid[i]=0, latch MADDRi/MDINi and set valid[i].
//    BUSY = valid, registered.
//    MW[i] while BUSY[i]=1 is ignored and never overwrites the buffer. A core holding MW
//    across the edge where BUSY falls has a second store accepted at the next edge.
//  - Arbitrate: combinational over valid[3:0]. Search starts at ptr, ascending, and wraps
//    3->0. On a grant g, ptr <= (g+1) mod 4.
//  - Issue: all outputs registered. At the edge after grant g, the outputs take these values
//    for exactly one cycle:
//      MEMWRITE=1, WADDR/WDATA = buffer g, WDONE=1<<g
//    valid[g] clears on that same edge. With no valid entry, MEMWRITE=0, WDONE=0,
//    WADDR/WDATA hold their last values.
//  - Throughput: one store per cycle, sustained.
//  - Latency: MW seen at edge k -> captured at k -> MEMWRITE high after edge k+1.
//    Minimum is 2 edges.
//  - Buffer reuse: BUSY[i] falls on the issuing edge. The earliest re-accept is the
//    following edge. Capture and issue never act on the same slot in the same cycle.
//  - Simultaneous requests: all four are captured together and drained in RR order over
//    4 consecutive cycles. No store is dropped and there are no idle cycles.
//  - Same address from several cores: each store is written separately, in grant order.
//    Memory ends with the last-granted core's data. There is no merging and no forwarding.
//  - Fairness: a pending core waits for at most 3 other grants.
//  - Reset mid-operation: pending stores are discarded. MEMWRITE drops immediately, without
//    waiting for clk. After release, no stale store is issued.
//  - No read/write ordering against the load controller. Software or the core pipeline
//    orders load-after-store to the same address.
// STRUCTURE
//  - Shared package: ADDR_W/DATA_W defaults, NCORES=4, core-index type (2 bits),
//    one-hot grant type (4 bits).
//  - Sub-module rr_arbiter4:
//      inputs   req[3:0], ptr[1:0]
//      outputs  gnt_onehot[3:0], gnt_idx[1:0], gnt_valid
//    Purely combinational. ptr is registered in the parent.
//  - Parent holds the 4 buffers, the valid bits, the ptr register and the output registers.
// TESTING
//  1. After reset: MW=0001, MADDR1=0x0010, MDIN1=0xABCD for 1 cycle
//     -> after 2 edges MEMWRITE=1 for 1 cycle, WADDR=0x0010, WDATA=0xABCD, WDONE=0001.
//     BUSY=0001 for exactly 1 cycle.
//  2. After reset: MW=1111 on one edge, with addrs 0x0100..0x0103 and data 0x1111..0x4444
//     -> 4 back-to-back writes in order core1..core4.
//     WDONE sequence 0001, 0010, 0100, 1000. BUSY goes 1111->1110->1100->1000->0000.
//  3. Fairness: core1 re-requests on every edge after each WDONE, while core3 is pending
//     -> core3 is issued within 2 grants. Grants alternate core1/core3, never core1 twice
//     while core3 is valid.
//  4. Hold while busy: MW[1] held 3 cycles, with data 0xAAAA then 0xBBBB while BUSY[1]=1
//     -> first write carries 0xAAAA. 0xBBBB is written only if MW is still high after
//     BUSY falls.
//  5. Same address: ptr=2 (previous grant core2), cores 2 and 4 store to 0x00FF with
//     0x2222 / 0x4444 -> core4 is written first, then core2. Memory holds 0x2222.
//  6. Mid-operation reset: 3 stores pending, pull rstn low between edges
//     -> MEMWRITE, BUSY and WDONE go to 0 with no clk edge. After release, with MW=0,
//     no MEMWRITE for 10 cycles.

Source files
------------

// File: rtl/data_store_controller_pkg.sv
// Shared widths, core count and index/grant types for the data-store write path.
// Imported by the arbiter and the top-level controller.
package data_store_controller_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int NCORES     = 4;

    typedef logic [1:0]        core_idx_t;
    typedef logic [NCORES-1:0] gnt_t;

    function automatic gnt_t idx_to_onehot(input core_idx_t idx);
        return gnt_t'(1) << idx;
    endfunction
endpackage

// File: rtl/data_store_controller_arb.sv
// Combinational 4-way round-robin arbiter: the search starts at ptr and wraps 3->0.
// The pointer register lives in the parent.
module rr_arbiter4
    import data_store_controller_pkg::*;
(
    input  gnt_t      req,
    input  core_idx_t ptr,
    output gnt_t      gnt_onehot,
    output core_idx_t gnt_idx,
    output logic      gnt_valid
);
    core_idx_t cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand       = ptr;
        // The 2-bit add wraps naturally, giving the 3->0 rollover.
        for (int off = 0; off < NCORES; off++) begin
            cand = ptr + core_idx_t'(off);
            if (!gnt_valid && req[cand]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = cand;
                gnt_onehot = idx_to_onehot(cand);
            end
        end
    end
endmodule

// File: rtl/data_store_controller.sv
// Serializes one buffered store per core onto the single data-memory write port.
// Each core has a one-entry buffer; a round-robin arbiter chooses one buffer per cycle.
module data_store_controller
    import data_store_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        MW,
    input  logic [ADDR_W-1:0] MADDR1,
    input  logic [ADDR_W-1:0] MADDR2,
    input  logic [ADDR_W-1:0] MADDR3,
    input  logic [ADDR_W-1:0] MADDR4,
    input  logic [DATA_W-1:0] MDIN1,
    input  logic [DATA_W-1:0] MDIN2,
    input  logic [DATA_W-1:0] MDIN3,
    input  logic [DATA_W-1:0] MDIN4,
    output logic [3:0]        BUSY,
    output logic [3:0]        WDONE,
    output logic              MEMWRITE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA
);
    logic [NCORES-1:0][ADDR_W-1:0] maddr_in;
    logic [NCORES-1:0][DATA_W-1:0] mdin_in;

    gnt_t                          valid_q, valid_d;
    core_idx_t                     ptr_q, ptr_d;
    logic [NCORES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [NCORES-1:0][DATA_W-1:0] data_q, data_d;
    logic                          memwrite_q, memwrite_d;
    gnt_t                          wdone_q, wdone_d;
    logic [ADDR_W-1:0]             waddr_q, waddr_d;
    logic [DATA_W-1:0]             wdata_q, wdata_d;

    gnt_t      gnt_onehot;
    core_idx_t gnt_idx;
    logic      gnt_valid;

    assign maddr_in = {MADDR4, MADDR3, MADDR2, MADDR1};
    assign mdin_in  = {MDIN4, MDIN3, MDIN2, MDIN1};

    rr_arbiter4 u_arb (
        .req        (valid_q),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    always_comb begin
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        memwrite_d = 1'b0;
        wdone_d    = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        if (gnt_valid) begin
            valid_d[gnt_idx] = 1'b0;
            ptr_d            = gnt_idx + core_idx_t'(1);
            memwrite_d       = 1'b1;
            wdone_d          = gnt_onehot;
            waddr_d          = addr_q[gnt_idx];
            wdata_d          = data_q[gnt_idx];
        end

        // Only empty slots capture, and only full slots are granted, so a slot is
        // never captured and issued on the same edge.
        for (int i = 0; i < NCORES; i++) begin
            if (MW[i] && !valid_q[i]) begin
                valid_d[i] = 1'b1;
                addr_d[i]  = maddr_in[i];
                data_d[i]  = mdin_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            memwrite_q <= 1'b0;
            wdone_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            memwrite_q <= memwrite_d;
            wdone_q    <= wdone_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign BUSY     = valid_q;
    assign WDONE    = wdone_q;
    assign MEMWRITE = memwrite_q;
    assign WADDR    = waddr_q;
    assign WDATA    = wdata_q;
endmodule

// File: tb/tb_data_store_controller.sv
// Directed scenarios plus a random phase for data_store_controller, checked every cycle
// against a reference model of pending stores and a last-granted-core fairness rule.
module tb_data_store_controller;
    logic        clk;
    logic        rstn;
    logic [3:0]  mw;
    logic [15:0] maddr [4];
    logic [15:0] mdin  [4];
    logic [3:0]  busy;
    logic [3:0]  wdone;
    logic        memwrite;
    logic [15:0] waddr;
    logic [15:0] wdata;

    int checks   = 0;
    int failures = 0;

    // Reference model: the set of pending stores and the most recently granted core.
    bit          pend  [4];
    logic [15:0] paddr [4];
    logic [15:0] pdata [4];
    int          last_g;
    logic        exp_mw;
    logic [3:0]  exp_done;
    logic [15:0] exp_wa;
    logic [15:0] exp_wd;
    logic [3:0]  prev_done;

    data_store_controller dut (
        .clk      (clk),
        .rstn     (rstn),
        .MW       (mw),
        .MADDR1   (maddr[0]),
        .MADDR2   (maddr[1]),
        .MADDR3   (maddr[2]),
        .MADDR4   (maddr[3]),
        .MDIN1    (mdin[0]),
        .MDIN2    (mdin[1]),
        .MDIN3    (mdin[2]),
        .MDIN4    (mdin[3]),
        .BUSY     (busy),
        .WDONE    (wdone),
        .MEMWRITE (memwrite),
        .WADDR    (waddr),
        .WDATA    (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] model_busy();
        logic [3:0] b;
        for (int c = 0; c < 4; c++) b[c] = pend[c];
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            pend[c]  = 1'b0;
            paddr[c] = '0;
            pdata[c] = '0;
        end
        last_g   = 3;
        exp_mw   = 1'b0;
        exp_done = '0;
        exp_wa   = '0;
        exp_wd   = '0;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit was_pend [4];
        int g;
        g = -1;
        for (int c = 0; c < 4; c++) was_pend[c] = pend[c];
        for (int k = 1; k <= 4; k++) begin
            if (g < 0 && pend[(last_g + k) % 4]) g = (last_g + k) % 4;
        end
        exp_mw   = 1'b0;
        exp_done = '0;
        if (g >= 0) begin
            exp_mw   = 1'b1;
            exp_done = 4'(1 << g);
            exp_wa   = paddr[g];
            exp_wd   = pdata[g];
            pend[g]  = 1'b0;
            last_g   = g;
        end
        for (int c = 0; c < 4; c++) begin
            if (mw[c] && !was_pend[c]) begin
                pend[c]  = 1'b1;
                paddr[c] = maddr[c];
                pdata[c] = mdin[c];
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".memwrite"}, 32'(memwrite), 32'(exp_mw));
        check({tag, ".wdone"},    32'(wdone),    32'(exp_done));
        check({tag, ".busy"},     32'(busy),     32'(model_busy()));
        check({tag, ".waddr"},    32'(waddr),    32'(exp_wa));
        check({tag, ".wdata"},    32'(wdata),    32'(exp_wd));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_core(input int c, input logic [15:0] a, input logic [15:0] d);
        maddr[c] = a;
        mdin[c]  = d;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        mw   = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset.memwrite", 32'(memwrite), 32'd0);
        check("reset.busy",     32'(busy),     32'd0);
        check("reset.wdone",    32'(wdone),    32'd0);
        rstn = 1'b1;
    endtask

    logic [3:0] seq_done [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] seq_busy [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        rstn = 1'b0;
        mw   = '0;
        for (int c = 0; c < 4; c++) set_core(c, '0, '0);
        model_reset();
        #2;
        check("reset_async.memwrite", 32'(memwrite), 32'd0);
        check("reset_async.waddr",    32'(waddr),    32'd0);

        // 1: single store from core1
        do_reset();
        mw = 4'b0001;
        set_core(0, 16'h0010, 16'hABCD);
        tick("t1.capture");
        check("t1.busy_set", 32'(busy), 32'h1);
        check("t1.no_write_yet", 32'(memwrite), 32'd0);
        mw = '0;
        tick("t1.issue");
        check("t1.memwrite", 32'(memwrite), 32'd1);
        check("t1.waddr", 32'(waddr), 32'h0010);
        check("t1.wdata", 32'(wdata), 32'hABCD);
        check("t1.wdone", 32'(wdone), 32'h1);
        check("t1.busy_clear", 32'(busy), 32'h0);
        tick("t1.idle");
        check("t1.memwrite_low", 32'(memwrite), 32'd0);
        check("t1.wdata_hold", 32'(wdata), 32'hABCD);

        // 2: all four cores at once
        do_reset();
        mw = 4'b1111;
        for (int c = 0; c < 4; c++) set_core(c, 16'h0100 + 16'(c), 16'h1111 * 16'(c + 1));
        tick("t2.capture");
        check("t2.busy_all", 32'(busy), 32'hF);
        mw = '0;
        for (int k = 0; k < 4; k++) begin
            tick("t2.drain");
            check("t2.wdone_seq", 32'(wdone), 32'(seq_done[k]));
            check("t2.busy_seq", 32'(busy), 32'(seq_busy[k]));
            check("t2.waddr_seq", 32'(waddr), 32'h0100 + 32'(k));
        end

        // 3: core1 keeps re-requesting while core3 is pending
        do_reset();
        mw = 4'b0101;
        set_core(0, 16'h0200, 16'h0C01);
        set_core(2, 16'h0300, 16'h0C03);
        prev_done = '0;
        for (int k = 0; k < 8; k++) begin
            tick("t3.fair");
            check("t3.no_double_core1", 32'(prev_done == 4'b0001 && wdone == 4'b0001), 32'd0);
            if (wdone != 4'b0000) prev_done = wdone;
        end
        mw = '0;
        repeat (3) tick("t3.drain");

        // 4: core2 holds MW through BUSY
        do_reset();
        mw = 4'b0010;
        set_core(1, 16'h0040, 16'hAAAA);
        tick("t4.capture");
        mdin[1] = 16'hBBBB;
        tick("t4.issue_first");
        check("t4.first_data", 32'(wdata), 32'hAAAA);
        tick("t4.reaccept");
        check("t4.reaccept_busy", 32'(busy), 32'h2);
        mw = '0;
        tick("t4.issue_second");
        check("t4.second_data", 32'(wdata), 32'hBBBB);

        // 5: same address from cores 2 and 4 with the pointer at core3
        do_reset();
        mw = 4'b0010;
        set_core(1, 16'h0001, 16'h0001);
        tick("t5.prime");
        mw = '0;
        tick("t5.prime_issue");
        mw = 4'b1010;
        set_core(1, 16'h00FF, 16'h2222);
        set_core(3, 16'h00FF, 16'h4444);
        tick("t5.capture");
        mw = '0;
        tick("t5.first");
        check("t5.first_core4", 32'(wdone), 32'h8);
        check("t5.first_data", 32'(wdata), 32'h4444);
        tick("t5.second");
        check("t5.second_core2", 32'(wdone), 32'h2);
        check("t5.final_mem", 32'(wdata), 32'h2222);

        // 6: reset in the middle of a drain
        do_reset();
        mw = 4'b1101;
        set_core(0, 16'h0500, 16'h5001);
        set_core(2, 16'h0502, 16'h5003);
        set_core(3, 16'h0503, 16'h5004);
        tick("t6.capture");
        mw = '0;
        tick("t6.first_issue");
        check("t6.mid_write", 32'(memwrite), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6.async_memwrite", 32'(memwrite), 32'd0);
        check("t6.async_busy", 32'(busy), 32'd0);
        check("t6.async_wdone", 32'(wdone), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick("t6.no_stale");
        end

        // Random traffic
        do_reset();
        for (int k = 0; k < 300; k++) begin
            mw = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) set_core(c, 16'($urandom), 16'($urandom));
            tick("rand");
        end
        mw = '0;
        repeat (5) tick("rand.drain");
        check("rand.all_drained", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
